// File: rtl/memory_read_sequencer_if.sv
// Purpose: bundles the command, memory-side and stream-side signals of the memory read sequencer.
// Latency: n/a (wiring only).
// Backpressure: iReady from the stream consumer; oValid/oData are held while stalled.
//
// Signal summary
//   command : iStart, iBaseAddress[ADDR_W], iLength[ADDR_W+1], iPortSel (0 = port a, 1 = port b)
//   memory  : oAddress[ADDR_W], oReadtoa, oReadtob, iDataOuta[DATA_W], iDataOutb[DATA_W]
//   stream  : oData[DATA_W], oValid, iReady
//   status  : oBusy, oDone, oChecksum[DATA_W] (only when CHECKSUM_EN is defined)
// modport master : the sequencer itself; modport slave : the surrounding memory/command/stream logic.
interface memory_read_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              iStart;
    logic [ADDR_W-1:0] iBaseAddress;
    logic [ADDR_W:0]   iLength;
    logic              iPortSel;
    logic [ADDR_W-1:0] oAddress;
    logic              oReadtoa;
    logic              oReadtob;
    logic [DATA_W-1:0] iDataOuta;
    logic [DATA_W-1:0] iDataOutb;
    logic [DATA_W-1:0] oData;
    logic              oValid;
    logic              iReady;
    logic              oBusy;
    logic              oDone;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] oChecksum;
`endif

    modport master (
        input  iStart, iBaseAddress, iLength, iPortSel, iDataOuta, iDataOutb, iReady,
`ifdef CHECKSUM_EN
        output oChecksum,
`endif
        output oAddress, oReadtoa, oReadtob, oData, oValid, oBusy, oDone
    );

    modport slave (
        output iStart, iBaseAddress, iLength, iPortSel, iDataOuta, iDataOutb, iReady,
`ifdef CHECKSUM_EN
        input  oChecksum,
`endif
        input  oAddress, oReadtoa, oReadtob, oData, oValid, oBusy, oDone
    );
endinterface

// File: rtl/memory_read_sequencer.sv
// Purpose: drains a burst of words from the dual-output memory and streams them out in address order.
// Latency: first oValid RD_LAT+1 cycles after the accepting edge; one word per cycle sustained.
// Backpressure: strobes only issue when a buffer slot is reserved for them; stalled stream holds data.
//
// Ports
//   Clock : rising-edge clock
//   Reset : synchronous, active-low reset
//   bus   : memory_read_sequencer_if.master (command, memory strobes/data, output stream, status)
// Optional feature: define CHECKSUM_EN to add bus.oChecksum, the mod-2**DATA_W sum of the
// words transferred in the current burst (cleared on accept, final from the oDone cycle).
// FIFO_DEPTH must be at least RD_LAT+1 to sustain one word per cycle.
module memory_read_sequencer #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    memory_read_sequencer_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] nextAddr;
    logic [ADDR_W-1:0] lastAddr;
    logic [ADDR_W:0]   remaining;
    logic              portSel;

    // Bit i set means a strobe issued i+1 cycles ago; the top bit marks data on the bus this cycle.
    logic [RD_LAT-1:0] captureVld;
    logic [RD_LAT-1:0] captureVldNext;

    logic [DATA_W-1:0] buffer [FIFO_DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     countNext;
    logic [CW-1:0]     inFlight;
    logic [CW-1:0]     freeSlots;

    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic              streamValid;
    logic [DATA_W-1:0] captureData;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept      = (state == IDLE) && bus.iStart && (bus.iLength != '0);
    assign streamValid = (count != '0);
    assign pop         = streamValid && bus.iReady;
    assign push        = captureVld[RD_LAT-1];
    assign captureData = portSel ? bus.iDataOutb : bus.iDataOuta;

    always_comb begin
        inFlight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inFlight = inFlight + CW'(captureVld[i]);
        end
    end

    // A slot freed by this cycle's transfer is already reusable: the word fetched now lands
    // RD_LAT cycles later, so counting it keeps full throughput at FIFO_DEPTH = RD_LAT+1.
    assign freeSlots = CW'(FIFO_DEPTH) - count + CW'(pop);
    assign issue     = (state == ISSUE) && (freeSlots > inFlight);

    always_comb begin
        captureVldNext    = captureVld << 1;
        captureVldNext[0] = issue;
    end

    assign countNext = count + CW'(push) - CW'(pop);

    // Outside a strobe the address bus shows the most recently strobed address.
    assign bus.oAddress = issue ? nextAddr : lastAddr;
    assign bus.oReadtoa = issue && !portSel;
    assign bus.oReadtob = issue && portSel;
    assign bus.oValid   = streamValid;
    assign bus.oData    = streamValid ? buffer[rdPtr] : '0;
    assign bus.oBusy    = (state == ISSUE) || (state == DRAIN);
    assign bus.oDone    = (state == DONE);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= IDLE;
            nextAddr   <= '0;
            lastAddr   <= '0;
            remaining  <= '0;
            portSel    <= 1'b0;
            captureVld <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
        end else begin
            captureVld <= captureVldNext;
            count      <= countNext;
            if (push) begin
                wrPtr <= ptrInc(wrPtr);
            end
            if (pop) begin
                rdPtr <= ptrInc(rdPtr);
            end
            if (issue) begin
                lastAddr  <= nextAddr;
                nextAddr  <= nextAddr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ISSUE;
                        nextAddr  <= bus.iBaseAddress;
                        remaining <= bus.iLength;
                        portSel   <= bus.iPortSel;
                    end
                end
                ISSUE: begin
                    if (issue && (remaining == (ADDR_W+1)'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Look at next-cycle occupancy so oDone follows the last transfer directly.
                    if ((countNext == '0) && (captureVldNext == '0)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer storage needs no reset: it is only observed through oData, which is gated by oValid.
    always_ff @(posedge Clock) begin
        if (Reset && push) begin
            buffer[wrPtr] <= captureData;
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + buffer[rdPtr];
        end
    end

    assign bus.oChecksum = checksum;
`endif
endmodule

// File: tb/tb_memory_read_sequencer.sv
// Purpose: self-checking bench for memory_read_sequencer with a behavioural memory and scoreboard.
// Latency: memory model returns strobed data RD_LAT cycles after the strobe.
// Backpressure: iReady driven always-high, toggling, or random per burst.
module tb_memory_read_sequencer;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 8;
    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    memory_read_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    memory_read_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    // Reference model state
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] expQ[$];
    logic [ADDR_W-1:0] addrQ[$];
    logic              expPort = 1'b0;
    logic [DATA_W-1:0] expSum = '0;
    logic [ADDR_W-1:0] lastStrobeAddr = '0;
    int issued = 0;
    int transferred = 0;
    int doneExpected = 0;
    int doneSeen = 0;
    int readyMode = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Memory model: a strobe seen in cycle t puts mem[addr] on that port's bus in cycle t+RD_LAT;
    // otherwise the bus carries junk so mistimed or wrong-port captures show up as data errors.
    initial begin
        logic [DATA_W-1:0] pipeA [RD_LAT];
        logic [DATA_W-1:0] pipeB [RD_LAT];
        logic [DATA_W-1:0] pendA;
        logic [DATA_W-1:0] pendB;
        for (int i = 0; i < RD_LAT; i++) begin
            pipeA[i] = '0;
            pipeB[i] = '0;
        end
        forever begin
            @(negedge Clock);
            pendA = bus.oReadtoa ? mem[bus.oAddress] : DATA_W'($urandom);
            pendB = bus.oReadtob ? mem[bus.oAddress] : DATA_W'($urandom);
            @(posedge Clock);
            #1;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipeA[i] = pipeA[i-1];
                pipeB[i] = pipeB[i-1];
            end
            pipeA[0] = pendA;
            pipeB[0] = pendB;
            bus.iDataOuta = pipeA[RD_LAT-1];
            bus.iDataOutb = pipeB[RD_LAT-1];
        end
    end

    // Ready driver
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            case (readyMode)
                0:       bus.iReady = 1'b1;
                1:       bus.iReady = ~bus.iReady;
                default: bus.iReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic              prevStall;
        logic [DATA_W:0]   prevVD;
        logic              strobe;
        prevStall = 1'b0;
        prevVD    = '0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                prevStall = 1'b0;
            end else begin
                strobe = bus.oReadtoa || bus.oReadtob;
                if (strobe) begin
                    issued++;
                    check("strobe_excl", 32'(bus.oReadtoa & bus.oReadtob), 32'd0);
                    check("strobe_port", 32'(bus.oReadtob), 32'(expPort));
                    check("busy_on_strobe", 32'(bus.oBusy), 32'd1);
                    if (addrQ.size() == 0) begin
                        check("extra_strobe_addr", 32'(bus.oAddress), 32'hFFFF_FFFF);
                    end else begin
                        check("address", 32'(bus.oAddress), 32'(addrQ.pop_front()));
                    end
                    lastStrobeAddr = bus.oAddress;
                end else begin
                    check("addr_hold", 32'(bus.oAddress), 32'(lastStrobeAddr));
                end
                if (prevStall) begin
                    check("stall_hold", 32'({bus.oValid, bus.oData}), 32'(prevVD));
                end
                if (bus.oValid && bus.iReady) begin
                    transferred++;
                    if (expQ.size() == 0) begin
                        check("extra_word", 32'(bus.oData), 32'hFFFF_FFFF);
                    end else begin
                        check("data", 32'(bus.oData), 32'(expQ.pop_front()));
                    end
                end
                if (strobe) begin
                    // Words fetched but not yet transferred must fit in the output buffer.
                    check("no_overflow", 32'((issued - transferred) <= FIFO_DEPTH), 32'd1);
                end
                if (bus.oDone) begin
                    doneSeen++;
                    check("done_drained", 32'(expQ.size() + addrQ.size()), 32'd0);
                    check("done_not_busy", 32'(bus.oBusy), 32'd0);
`ifdef CHECKSUM_EN
                    check("checksum", 32'(bus.oChecksum), 32'(expSum));
`endif
                end
                prevStall = bus.oValid && !bus.iReady;
                prevVD    = {bus.oValid, bus.oData};
            end
        end
    end

    task automatic waitIdle();
        int k = 0;
        while ((bus.oBusy || bus.oDone) && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) timeoutFail("wait_idle");
    endtask

    task automatic driveStart(input int base, input int len, input logic port);
        bus.iStart       = 1'b1;
        bus.iBaseAddress = ADDR_W'(base);
        bus.iLength      = (ADDR_W+1)'(len);
        bus.iPortSel     = port;
        if (len != 0) begin
            expPort = port;
            expSum  = '0;
            for (int i = 0; i < len; i++) begin
                int a;
                a = (base + i) % DEPTH;
                addrQ.push_back(ADDR_W'(a));
                expQ.push_back(mem[a]);
                expSum = expSum + mem[a];
            end
            doneExpected++;
        end
    endtask

    task automatic startBurst(input int base, input int len, input logic port);
        waitIdle();
        driveStart(base, len, port);
        step();
        bus.iStart = 1'b0;
    endtask

    task automatic waitDone();
        int k = 0;
        while (doneSeen < doneExpected && k < 3000) begin
            step();
            k++;
        end
        if (k >= 3000) timeoutFail("wait_done");
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_addr"},  32'(bus.oAddress), 32'd0);
        check({tag, "_rda"},   32'(bus.oReadtoa), 32'd0);
        check({tag, "_rdb"},   32'(bus.oReadtob), 32'd0);
        check({tag, "_valid"}, 32'(bus.oValid),   32'd0);
        check({tag, "_data"},  32'(bus.oData),    32'd0);
        check({tag, "_busy"},  32'(bus.oBusy),    32'd0);
        check({tag, "_done"},  32'(bus.oDone),    32'd0);
`ifdef CHECKSUM_EN
        check({tag, "_csum"},  32'(bus.oChecksum), 32'd0);
`endif
    endtask

    initial begin
        int lat;
        int run;
        int t0;
        int k;
        bus.iStart       = 1'b0;
        bus.iBaseAddress = '0;
        bus.iLength      = '0;
        bus.iPortSel     = 1'b0;
        bus.iReady       = 1'b1;
        bus.iDataOuta    = '0;
        bus.iDataOutb    = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);

        // Reset state
        Reset = 1'b0;
        repeat (3) step();
        @(negedge Clock);
        checkAllZero("reset");
        step();
        Reset = 1'b1;
        step();

        // Burst of 8 from address 0 on port a, ready always high: latency and back-to-back words
        for (int i = 0; i < 8; i++) mem[i] = DATA_W'(10 + i);
        readyMode = 0;
        driveStart(0, 8, 1'b0);
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge Clock);
            if (bus.oValid) break;
            @(posedge Clock);
            lat++;
        end
        check("first_valid_latency", 32'(lat), 32'(RD_LAT + 1));
        run = 0;
        while (bus.oValid && run < 20) begin
            run++;
            @(negedge Clock);
        end
        check("consecutive_words", 32'(run), 32'd8);
        check("done_after_last", 32'(bus.oDone), 32'd1);
        step();

        // Wrapping burst on port b with random backpressure
        readyMode = 2;
        startBurst(1020, 8, 1'b1);
        waitDone();

        // 16 words with ready toggling every cycle
        readyMode = 1;
        startBurst($urandom_range(0, DEPTH - 1), 16, 1'($urandom_range(0, 1)));
        waitDone();

        // Zero-length command is a no-op
        readyMode = 0;
        startBurst(5, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("len0_busy", 32'(bus.oBusy), 32'd0);
            check("len0_done", 32'(bus.oDone), 32'd0);
            check("len0_strobe", 32'(bus.oReadtoa | bus.oReadtob), 32'd0);
        end
        step();

        // Second command while busy is ignored
        readyMode = 2;
        startBurst(200, 12, 1'b1);
        repeat (3) step();
        bus.iStart       = 1'b1;
        bus.iBaseAddress = ADDR_W'(0);
        bus.iLength      = (ADDR_W+1)'(5);
        bus.iPortSel     = 1'b0;
        step();
        bus.iStart = 1'b0;
        waitDone();

        // Reset in the middle of a 16-word burst, then a fresh 2-word burst
        readyMode = 0;
        t0 = transferred;
        startBurst(300, 16, 1'b0);
        k = 0;
        while ((transferred - t0) < 5 && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) timeoutFail("wait_word5");
        Reset = 1'b0;
        expQ.delete();
        addrQ.delete();
        issued         = 0;
        transferred    = 0;
        lastStrobeAddr = '0;
        doneExpected   = doneSeen;
        step();
        @(negedge Clock);
        checkAllZero("midreset");
        step();
        Reset = 1'b1;
        step();
        readyMode = 2;
        startBurst(100, 2, 1'b0);
        waitDone();

        // Checksum wraps modulo 256
        mem[0] = 8'h80;
        mem[1] = 8'h80;
        mem[2] = 8'h01;
        mem[3] = 8'h02;
        readyMode = 0;
        startBurst(0, 4, 1'b0);
        waitDone();
`ifdef CHECKSUM_EN
        check("checksum_wrap", 32'(bus.oChecksum), 32'h03);
`endif

        // Random bursts
        for (int n = 0; n < 12; n++) begin
            readyMode = $urandom_range(0, 2);
            startBurst($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1'($urandom_range(0, 1)));
            waitDone();
        end

        repeat (5) step();
        check("done_total", 32'(doneSeen), 32'(doneExpected));
        check("queues_empty", 32'(expQ.size() + addrQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
